multicycle_core: RTL and testbench

//  Multi-cycle MIPS-subset core: one shared ALU and one unified memory port, reused across states.

---
 rtl/multicycle_core.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core sharing one ALU and one req/ready memory port; beq/j 3, R/addi/sw 4, lw 5 cycles.
// Memory stalls hold the core in FETCH/MEM with request fields stable; illegal or misaligned ops park it in HALT.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              retire_o,
  output logic [31:0]       pc_o,
  output logic              halted_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        retire_q, retire_d;
  logic [31:0] gpr_q [32];

  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] sext_imm;
  logic [31:0] addr_sum;
  logic [31:0] r_result;
  logic        r_legal;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign imm26    = ir_q[25:0];
  assign sext_imm = {{16{imm16[15]}}, imm16};
  assign addr_sum = a_q + sext_imm;

  always_comb begin
    r_result = '0;
    r_legal  = 1'b1;
    case (funct)
      F_ADD:   r_result = a_q + b_q;
      F_SUB:   r_result = a_q - b_q;
      F_AND:   r_result = a_q & b_q;
      F_OR:    r_result = a_q | b_q;
      F_SLT:   r_result = {31'b0, ($signed(a_q) < $signed(b_q))};
      default: r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    retire_d  = 1'b0;
    gpr_we    = 1'b0;
    gpr_waddr = rt;
    gpr_wdata = alu_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = gpr_q[rs];
        b_d     = gpr_q[rt];
        // Branch target precomputed here so EXEC only has to compare.
        alu_d   = pc_q + {sext_imm[29:0], 2'b00};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_R: begin
            alu_d   = r_result;
            state_d = r_legal ? S_WB : S_HALT;
          end
          OP_ADDI: begin
            alu_d   = addr_sum;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = addr_sum;
            state_d = (addr_sum[1:0] != 2'b00) ? S_HALT : S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = alu_q;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OP_J: begin
            pc_d     = {pc_q[31:28], imm26, 2'b00};
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_q;
        if (mem_ready_i) begin
          if (op == OP_SW) begin
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata_i;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        gpr_we    = 1'b1;
        gpr_waddr = (op == OP_R) ? rd : rt;
        gpr_wdata = (op == OP_LW) ? mdr_q : alu_q;
        retire_d  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
    end
  end

  // $0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (gpr_we && (gpr_waddr != 5'd0)) begin
      gpr_q[gpr_waddr] <= gpr_wdata;
    end
  end

  // Reset sits in FETCH, so the request is gated to drop immediately on reset.
  assign mem_req_o   = mem_req & ~reset_i;
  assign mem_we_o    = mem_we & ~reset_i;
  assign mem_addr_o  = mem_addr[ADDR_W-1:0];
  assign mem_wdata_o = b_q;
  assign retire_o    = retire_q;
  assign pc_o        = pc_q;
  assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: unified memory model with programmable wait states.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        retire;
  logic [31:0] pc;
  logic        halted;

  logic [31:0] mem [0:1023];
  logic        ld_vld;
  logic [9:0]  ld_idx;
  logic [31:0] ld_dat;
  int          wait_n;
  int          cnt;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] prog [20] = '{
    32'h20010005,  // 0x40 addi $1,$0,5
    32'h2002FFFD,  // 0x44 addi $2,$0,-3
    32'h00221820,  // 0x48 add  $3,$1,$2
    32'h0041202A,  // 0x4C slt  $4,$2,$1
    32'hAC030008,  // 0x50 sw   $3,8($0)
    32'h8C050008,  // 0x54 lw   $5,8($0)
    32'hAC05000C,  // 0x58 sw   $5,12($0)
    32'hAC040010,  // 0x5C sw   $4,16($0)
    32'h00223022,  // 0x60 sub  $6,$1,$2
    32'h00223824,  // 0x64 and  $7,$1,$2
    32'h00224025,  // 0x68 or   $8,$1,$2
    32'h0022482A,  // 0x6C slt  $9,$1,$2
    32'hAC060014,  // 0x70 sw   $6,20($0)
    32'hAC070018,  // 0x74 sw   $7,24($0)
    32'hAC08001C,  // 0x78 sw   $8,28($0)
    32'hAC090020,  // 0x7C sw   $9,32($0)
    32'h20000007,  // 0x80 addi $0,$0,7
    32'hAC000024,  // 0x84 sw   $0,36($0)
    32'h10220005,  // 0x88 beq  $1,$2,+5 (not taken)
    32'h08000100   // 0x8C j    0x100
  };

  always #5 clk = ~clk;

  multicycle_core #(.RESET_PC(32'h0000_0040), .ADDR_W(32)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .mem_req_o   (req),
    .mem_we_o    (we),
    .mem_addr_o  (addr),
    .mem_wdata_o (wdata),
    .mem_rdata_i (rdata),
    .mem_ready_i (ready),
    .retire_o    (retire),
    .pc_o        (pc),
    .halted_o    (halted)
  );

  assign rdata = mem[addr[11:2]];
  assign ready = (cnt >= wait_n);

  always @(posedge clk) begin
    if (ld_vld) mem[ld_idx] <= ld_dat;
    else if (req && ready && we) mem[addr[11:2]] <= wdata;
    if (!req || ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_idx = idx[9:0];
    ld_dat = d;
    ld_vld = 1'b1;
    @(negedge clk);
    ld_vld = 1'b0;
  endtask

  task automatic wait_retire(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (retire !== 1'b1 && n < 40);
    chk({tag, "_retire"}, 32'(retire), 32'd1);
  endtask

  // Expects reset asserted on entry; leaves it asserted on exit.
  task automatic halt_case(input string tag, input logic [31:0] instr);
    logic [31:0] rv;
    logic        anyreq;
    load(16, instr);
    @(negedge clk);
    rst    = 1'b0;
    rv     = '0;
    anyreq = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rv[k] = retire;
      if (k >= 3) anyreq = anyreq | req;
      if (k == 2) chk({tag, "_halted_before"}, 32'(halted), 32'd0);
      if (k == 3) chk({tag, "_halted"}, 32'(halted), 32'd1);
    end
    chk({tag, "_no_retire"}, rv, 32'd0);
    chk({tag, "_no_req"}, 32'(anyreq), 32'd0);
    chk({tag, "_pc_frozen"}, pc, 32'h44);
    rst = 1'b1;
    #1;
    chk({tag, "_reset_clears_halt"}, 32'(halted), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    rst    = 1'b1;
    wait_n = 0;
    ld_vld = 1'b0;
    ld_idx = '0;
    ld_dat = '0;
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", pc, 32'h40);

    for (int i = 2; i <= 9; i++) load(i, 32'hDEADBEEF);
    for (int i = 0; i < 20; i++) load(16 + i, prog[i]);
    load(256, 32'h1000FFFF);  // 0x400 beq $0,$0,-1

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req", 32'(req), 32'd1);
    chk("first_addr", addr, 32'h40);
    chk("first_pc", pc, 32'h40);
    chk("first_halted", 32'(halted), 32'd0);

    rv = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      rv[k] = retire;
    end
    chk("retire_4_8_12_16", rv, 32'h0001_1110);

    // Two wait states on every access for the sw/lw pair.
    wait_n = 2;
    rv = '0;
    for (int k = 17; k <= 33; k++) begin
      @(negedge clk);
      rv[k-17] = retire;
      if (k >= 21 && k <= 23) begin
        chk("sw_req_held", 32'(req), 32'd1);
        chk("sw_we_held", 32'(we), 32'd1);
        chk("sw_addr_held", addr, 32'h8);
        chk("sw_wdata_held", wdata, 32'd2);
      end
      if (k >= 29 && k <= 31) begin
        chk("lw_req_held", 32'(req), 32'd1);
        chk("lw_we_held", 32'(we), 32'd0);
        chk("lw_addr_held", addr, 32'h8);
      end
    end
    chk("retire_sw24_lw33", rv, 32'h0001_0080);
    chk("mem_sw_8", mem[2], 32'd2);
    wait_n = 0;

    repeat (12) wait_retire("body");
    wait_retire("beq_nt");
    chk("pc_beq_not_taken", pc, 32'h8C);
    wait_retire("jump");
    chk("pc_jump", pc, 32'h400);
    wait_retire("beq_t1");
    chk("pc_beq_taken1", pc, 32'h400);
    wait_retire("beq_t2");
    chk("pc_beq_taken2", pc, 32'h400);

    chk("r3_add", mem[2], 32'd2);
    chk("r5_lw", mem[3], 32'd2);
    chk("r4_slt", mem[4], 32'd1);
    chk("r6_sub", mem[5], 32'd8);
    chk("r7_and", mem[6], 32'd5);
    chk("r8_or", mem[7], 32'hFFFF_FFFD);
    chk("r9_slt_signed", mem[8], 32'd0);
    chk("r0_stays_zero", mem[9], 32'd0);

    rst = 1'b1;
    #1;
    chk("rerst_pc", pc, 32'h40);
    halt_case("illegal_op", 32'hFC00_0000);
    halt_case("illegal_funct", 32'h0000_003F);
    halt_case("misaligned_lw", 32'h8C05_0006);

    // Reset while a fetch is stalled.
    load(16, 32'h2001_0005);
    wait_n = 1000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_req", 32'(req), 32'd1);
    chk("stall_addr", addr, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_req_drop", 32'(req), 32'd0);
    wait_n = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("refetch_req", 32'(req), 32'd1);
    chk("refetch_addr", addr, 32'h40);
    rv = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rv[k] = retire;
    end
    chk("refetch_retire_4", rv, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
